// File: rtl/alu_bus_driver.sv
// alu_bus_driver: sequences one ALU operation (BEGIN, operand feed over INBUS, result capture from OUTBUS) behind request/result handshakes
//   clk, reset_input (sync, active-high)
//   req_valid/req_ready, req_op, req_x[2W], req_y[W]      : request in
//   alu_begin, alu_op_code, alu_load_a/q/m, inbus          : ALU control/operand side
//   alu_push_a/q, outbus, alu_end                          : ALU result side
//   res_valid/res_ready, res_hi, res_lo, res_error         : result out
//   Optional watchdog: define ALU_BUS_DRIVER_TIMEOUT_EN
module alu_bus_driver #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_input,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0]   req_y,
  output logic               alu_begin,
  output logic [1:0]         alu_op_code,
  input  logic               alu_load_a,
  input  logic               alu_load_q,
  input  logic               alu_load_m,
  output logic [WIDTH-1:0]   inbus,
  input  logic               alu_push_a,
  input  logic               alu_push_q,
  input  logic [WIDTH-1:0]   outbus,
  input  logic               alu_end,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               res_error
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d, op_q, op_d;
  logic [2*WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d, cap_a_q, cap_a_d, cap_q_q, cap_q_d, word_a, word_q;
  logic is_idle, is_start, is_run, is_done, timeout;
  assign is_idle  = state_q == IDLE;
  assign is_start = state_q == START;
  assign is_run   = state_q == RUN;
  assign is_done  = state_q == DONE;
  assign req_ready   = is_idle;
  assign alu_begin   = is_start;
  assign alu_op_code = op_q;
  assign res_valid   = is_done;
  // op_q[1] set means mul/div (Q register in use); op 11 is div with a split dividend
  assign word_a = (op_q == 2'b11) ? x_q[2*WIDTH-1:WIDTH] : op_q[1] ? '0 : x_q[WIDTH-1:0];
  assign word_q = op_q[1] ? x_q[WIDTH-1:0] : '0;
  assign inbus  = !(is_start || is_run) ? '0 : alu_load_a ? word_a : alu_load_q ? word_q : alu_load_m ? y_q : '0;
  assign res_hi = (!is_done || res_error || !op_q[1]) ? '0 : cap_a_q;
  assign res_lo = (!is_done || res_error) ? '0 : op_q[1] ? cap_q_q : cap_a_q;
  always_comb begin
    state_d = (is_idle && req_valid) ? START : is_start ? RUN : (is_run && (alu_end || timeout)) ? DONE : (is_done && res_ready) ? IDLE : state_q;
    op_d    = (is_idle && req_valid) ? req_op : op_q;
    x_d     = (is_idle && req_valid) ? req_x : x_q;
    y_d     = (is_idle && req_valid) ? req_y : y_q;
    cap_a_d = is_start ? '0 : (is_run && alu_push_a) ? outbus : cap_a_q;
    cap_q_d = is_start ? '0 : (is_run && alu_push_q) ? outbus : cap_q_q;
  end
  always_ff @(posedge clk) begin
    if (reset_input) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cap_a_q <= '0;
      cap_q_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cap_a_q <= cap_a_d;
      cap_q_q <= cap_q_d;
    end
  end
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic err_q, err_d;
  // Firing when the count reaches 255 puts DONE exactly 256 cycles after BEGIN; a real END wins
  assign timeout = is_run && !alu_end && (wdog_d == 8'hff);
  always_comb begin
    wdog_d = is_start ? 8'h00 : is_run ? wdog_q + 8'h01 : wdog_q;
    err_d  = timeout ? 1'b1 : (is_done && !res_ready) ? err_q : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset_input) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign res_error = err_q;
`else
  assign timeout   = 1'b0;
  assign res_error = 1'b0;
`endif
endmodule

// File: tb/tb_alu_bus_driver.sv
// tb_alu_bus_driver: directed self-checking bench for alu_bus_driver
module tb_alu_bus_driver;
  logic clk = 1'b0, reset_input = 1'b0, req_valid = 1'b0, req_ready, alu_begin;
  logic [1:0] req_op = 2'b00, alu_op_code;
  logic [15:0] req_x = '0;
  logic [7:0] req_y = '0, inbus, outbus = '0, res_hi, res_lo;
  logic alu_load_a = 1'b0, alu_load_q = 1'b0, alu_load_m = 1'b0, alu_push_a = 1'b0, alu_push_q = 1'b0;
  logic alu_end = 1'b0, res_valid, res_ready = 1'b0, res_error;
  int checks = 0, errors = 0;

  alu_bus_driver #(.WIDTH(8)) dut (
    .clk(clk), .reset_input(reset_input), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .alu_begin(alu_begin), .alu_op_code(alu_op_code),
    .alu_load_a(alu_load_a), .alu_load_q(alu_load_q), .alu_load_m(alu_load_m), .inbus(inbus),
    .alu_push_a(alu_push_a), .alu_push_q(alu_push_q), .outbus(outbus), .alu_end(alu_end),
    .res_valid(res_valid), .res_ready(res_ready), .res_hi(res_hi), .res_lo(res_lo), .res_error(res_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    {alu_load_a, alu_load_q, alu_load_m, alu_push_a, alu_push_q, alu_end} = '0;
    outbus = '0;
  endtask

  // Presents a request for one edge; returns with the DUT in START
  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y);
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_input = 1'b1; req_valid = 1'b1; res_ready = 1'b1; alu_end = 1'b1;
    step(); step();
    reset_input = 1'b0; req_valid = 1'b0; res_ready = 1'b0; alu_end = 1'b0; alu_load_a = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (alu_begin !== 1'b0) begin errors++; $display("FAIL reset_alu_begin: got %b want 0", alu_begin); end
    checks++; if (alu_op_code !== 2'b00) begin errors++; $display("FAIL reset_op_code: got %b want 00", alu_op_code); end
    checks++; if (inbus !== 8'h00) begin errors++; $display("FAIL reset_inbus: got %h want 00", inbus); end
    checks++; if ({res_valid, res_error, res_hi, res_lo} !== 18'h0) begin errors++; $display("FAIL reset_results: got v=%b e=%b hi=%h lo=%h want all 0", res_valid, res_error, res_hi, res_lo); end
    clear_strobes();
  endtask

  task automatic test_add();
    issue(2'b00, 16'h0025, 8'h13);
    checks++; if (alu_begin !== 1'b1 || alu_op_code !== 2'b00) begin errors++; $display("FAIL add_begin: got begin=%b op=%b want 1/00", alu_begin, alu_op_code); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL add_req_ready_start: got %b want 0", req_ready); end
    step();
    checks++; if (alu_begin !== 1'b0) begin errors++; $display("FAIL add_begin_pulse: got %b want 0", alu_begin); end
    alu_load_a = 1'b1; #1;
    checks++; if (inbus !== 8'h25) begin errors++; $display("FAIL add_load_a: got %h want 25", inbus); end
    alu_load_m = 1'b1; #1;
    checks++; if (inbus !== 8'h25) begin errors++; $display("FAIL add_prio_a_over_m: got %h want 25", inbus); end
    step();
    alu_load_a = 1'b0; #1;
    checks++; if (inbus !== 8'h13) begin errors++; $display("FAIL add_load_m: got %h want 13", inbus); end
    step();
    alu_load_m = 1'b0; alu_push_a = 1'b1; outbus = 8'h38; alu_end = 1'b1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early: got %b want 0", res_valid); end
    step();
    clear_strobes();
    checks++; if (res_valid !== 1'b1 || res_lo !== 8'h38 || res_hi !== 8'h00 || res_error !== 1'b0) begin errors++; $display("FAIL add_result: got v=%b hi=%h lo=%h e=%b want 1/00/38/0", res_valid, res_hi, res_lo, res_error); end
    alu_load_a = 1'b1; #1;
    checks++; if (inbus !== 8'h00) begin errors++; $display("FAIL add_inbus_done: got %h want 00", inbus); end
    alu_load_a = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_release: got v=%b rdy=%b want 0/1", res_valid, req_ready); end
  endtask

  task automatic test_mul();
    issue(2'b10, 16'h0007, 8'h06);
    checks++; if (alu_op_code !== 2'b10) begin errors++; $display("FAIL mul_op_code: got %b want 10", alu_op_code); end
    step();
    alu_load_q = 1'b1; #1;
    checks++; if (inbus !== 8'h07) begin errors++; $display("FAIL mul_load_q: got %h want 07", inbus); end
    step();
    alu_load_q = 1'b0; alu_load_m = 1'b1; #1;
    checks++; if (inbus !== 8'h06) begin errors++; $display("FAIL mul_load_m: got %h want 06", inbus); end
    step();
    alu_load_m = 1'b0; alu_push_a = 1'b1; outbus = 8'h00;
    step();
    alu_push_a = 1'b0; alu_push_q = 1'b1; outbus = 8'h2A; alu_end = 1'b1;
    step();
    clear_strobes();
    checks++; if (res_valid !== 1'b1 || res_hi !== 8'h00 || res_lo !== 8'h2A) begin errors++; $display("FAIL mul_result: got v=%b hi=%h lo=%h want 1/00/2a", res_valid, res_hi, res_lo); end
    checks++; if (alu_op_code !== 2'b10) begin errors++; $display("FAIL mul_op_hold: got %b want 10", alu_op_code); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_div();
    issue(2'b11, 16'h0064, 8'h07);
    step();
    alu_load_a = 1'b1; #1;
    checks++; if (inbus !== 8'h00) begin errors++; $display("FAIL div_load_a: got %h want 00", inbus); end
    alu_load_a = 1'b0; alu_load_q = 1'b1; #1;
    checks++; if (inbus !== 8'h64) begin errors++; $display("FAIL div_load_q: got %h want 64", inbus); end
    alu_load_m = 1'b1; #1;
    checks++; if (inbus !== 8'h64) begin errors++; $display("FAIL div_prio_q_over_m: got %h want 64", inbus); end
    alu_load_q = 1'b0; #1;
    checks++; if (inbus !== 8'h07) begin errors++; $display("FAIL div_load_m: got %h want 07", inbus); end
    step();
    alu_load_m = 1'b0; alu_push_q = 1'b1; outbus = 8'h0E;
    step();
    alu_push_q = 1'b0; alu_push_a = 1'b1; outbus = 8'h02; alu_end = 1'b1;
    step();
    clear_strobes();
    checks++; if (res_valid !== 1'b1 || res_lo !== 8'h0E || res_hi !== 8'h02) begin errors++; $display("FAIL div_result: got v=%b hi=%h lo=%h want 1/02/0e", res_valid, res_hi, res_lo); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    issue(2'b00, 16'h00AA, 8'h55);
    step(); step(); step();
    reset_input = 1'b1; alu_end = 1'b1; alu_push_a = 1'b1; outbus = 8'hFF;
    step();
    reset_input = 1'b0; clear_strobes(); alu_load_a = 1'b1; #1;
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL midrun_reset_state: got rdy=%b v=%b want 1/0", req_ready, res_valid); end
    checks++; if (inbus !== 8'h00 || alu_op_code !== 2'b00) begin errors++; $display("FAIL midrun_reset_regs: got inbus=%h op=%b want 00/00", inbus, alu_op_code); end
    alu_load_a = 1'b0;
    issue(2'b01, 16'h0009, 8'h04);
    checks++; if (alu_begin !== 1'b1 || alu_op_code !== 2'b01) begin errors++; $display("FAIL midrun_new_begin: got begin=%b op=%b want 1/01", alu_begin, alu_op_code); end
    step();
    alu_load_a = 1'b1; #1;
    checks++; if (inbus !== 8'h09) begin errors++; $display("FAIL midrun_new_load_a: got %h want 09", inbus); end
    alu_load_a = 1'b0; alu_push_a = 1'b1; outbus = 8'h05; alu_end = 1'b1;
    step();
    clear_strobes();
    checks++; if (res_valid !== 1'b1 || res_lo !== 8'h05 || res_hi !== 8'h00) begin errors++; $display("FAIL midrun_new_result: got v=%b hi=%h lo=%h want 1/00/05", res_valid, res_hi, res_lo); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(2'b10, 16'h0010, 8'h10);
    step();
    alu_push_a = 1'b1; outbus = 8'h01;
    step();
    alu_push_a = 1'b0; alu_push_q = 1'b1; outbus = 8'h00; alu_end = 1'b1;
    step();
    clear_strobes();
    alu_push_a = 1'b1; alu_push_q = 1'b1; outbus = 8'hFF; alu_end = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1 || res_hi !== 8'h01 || res_lo !== 8'h00 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got v=%b hi=%h lo=%h rdy=%b want 1/01/00/0", i, res_valid, res_hi, res_lo, req_ready); end
      step();
    end
    clear_strobes(); req_valid = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", res_valid, req_ready); end
  endtask

  task automatic test_no_end();
    int n;
    issue(2'b00, 16'h0001, 8'h01);
    n = 0;
    while (!res_valid && n < 300) begin step(); n++; end
`ifdef ALU_BUS_DRIVER_TIMEOUT_EN
    checks++; if (n !== 256 || res_error !== 1'b1 || res_lo !== 8'h00) begin errors++; $display("FAIL timeout: got cycles=%0d e=%b lo=%h want 256/1/00", n, res_error, res_lo); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
    checks++; if (res_error !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL timeout_clear: got e=%b rdy=%b want 0/1", res_error, req_ready); end
`else
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b0 || res_error !== 1'b0) begin errors++; $display("FAIL no_timeout: got v=%b rdy=%b e=%b after %0d cycles want 0/0/0", res_valid, req_ready, res_error, n); end
    alu_end = 1'b1; step(); alu_end = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL late_end: got v=%b want 1", res_valid); end
    res_ready = 1'b1; step(); res_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_reset_mid_run();
    test_backpressure();
    test_no_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
